// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side drain stage.
// Holds the drain-stage state type, the buffer occupancy width and the gray-code helper.
package fifo_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 5'd1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry shift buffer behind the FIFO read port: head is always at r_head,
// so the output data comes straight from a register. Clear wins over push/pop.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [OCC_W-1:0] o_level
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [OCC_W-1:0] r_level;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic [OCC_W-1:0] w_level_nxt;

    // Next head/tail/level from the push/pop combination at the current level
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_level_nxt = r_level;
        if (i_clr) begin
            w_level_nxt = 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    case (r_level)
                        2'd0: begin
                            w_head_nxt  = i_data;
                            w_level_nxt = 2'd1;
                        end
                        2'd1: begin
                            w_tail_nxt  = i_data;
                            w_level_nxt = 2'd2;
                        end
                        default: w_level_nxt = r_level;
                    endcase
                end
                2'b01: begin
                    case (r_level)
                        2'd1:    w_level_nxt = 2'd0;
                        2'd2: begin
                            w_head_nxt  = r_tail;
                            w_level_nxt = 2'd1;
                        end
                        default: w_level_nxt = r_level;
                    endcase
                end
                2'b11: begin
                    case (r_level)
                        2'd1:    w_head_nxt = i_data;
                        2'd2: begin
                            w_head_nxt = r_tail;
                            w_tail_nxt = i_data;
                        end
                        default: begin
                            w_head_nxt  = i_data;
                            w_level_nxt = 2'd1;
                        end
                    endcase
                end
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Buffer storage and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= {WIDTH{1'b0}};
            r_tail  <= {WIDTH{1'b0}};
            r_level <= 2'd0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_level <= w_level_nxt;
        end
    end

    assign o_head  = r_head;
    assign o_level = r_level;

    fifo_skid_buf_chk u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_push  (i_push),
        .i_pop   (i_pop),
        .i_level (r_level)
    );

endmodule

// File: rtl/fifo_skid_buf_chk.sv
// Property checker for the 2-entry drain buffer: the pop rule upstream must
// never let it be written while full or read while empty.
module fifo_skid_buf_chk
    import fifo_pkg::*;
(
    input logic             i_clk,
    input logic             i_rst_n,
    input logic             i_clr,
    input logic             i_push,
    input logic             i_pop,
    input logic [OCC_W-1:0] i_level
);

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_clr && (i_level == 2'd2)));

    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_pop && !i_clr && (i_level == 2'd0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: hides the FIFO read latency behind a
// 2-entry buffer and presents a valid/ready stream. FIFO_RD_STREAM_LAST_EN enables burst framing.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BURST_LEN  = 4,
    parameter int BCNT_WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic             rd_error_i,
    output logic             rd_en_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             flush_i,
    output logic             err_o,
    output logic [1:0]       level_o
);

    rd_state_e        r_state;
    logic             r_inflight;
    logic             r_err;
    logic             w_run;
    logic             w_xfer;
    logic             w_accept;
    logic             w_clr;
    logic             w_push;
    logic             w_late;
    logic [2:0]       w_need;
    logic [OCC_W-1:0] w_level;
    logic [WIDTH-1:0] w_head;

    assign w_run    = (r_state == RUN);
    assign w_xfer   = out_valid_o && out_ready_i;
    assign w_accept = w_xfer && w_run && !flush_i;
    assign w_clr    = w_run && flush_i;
    assign w_push   = r_inflight && w_run;
    assign w_late   = r_inflight && w_run && (w_level == 2'd2);

    // Slots the buffer would hold after this edge if we issued one more pop
    always_comb begin
        w_need = {1'b0, w_level} + {2'b00, r_inflight} - {2'b00, w_xfer};
    end

    // Gated by rst_n_i so the FIFO is not popped while the stage is held in reset
    assign rd_en_o = rst_n_i && w_run && !empty_i && (w_need <= 3'd1);

    // RUN/FLUSH sequencing; FLUSH waits out any read still in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush_i) r_state <= FLUSH;
                    else         r_state <= RUN;
                end
                FLUSH: begin
                    if (!r_inflight) r_state <= RUN;
                    else             r_state <= FLUSH;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // In-flight read tracking and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= rd_en_o;
            if (rd_error_i || w_late) r_err <= 1'b1;
            else                      r_err <= r_err;
        end
    end

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  (rdata_i),
        .i_pop   (w_accept),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign out_valid_o = (w_level != 2'd0);
    assign out_data_o  = w_head;
    assign level_o     = w_level;
    assign err_o       = r_err;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam logic [BCNT_WIDTH-1:0] BCNT_MAX = BCNT_WIDTH'(BURST_LEN - 1);

    logic [BCNT_WIDTH-1:0] r_bcnt;

    // Beat position within the current burst; a flush restarts the burst
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bcnt <= {BCNT_WIDTH{1'b0}};
        end else if (w_clr) begin
            r_bcnt <= {BCNT_WIDTH{1'b0}};
        end else if (w_accept) begin
            if (r_bcnt == BCNT_MAX) r_bcnt <= {BCNT_WIDTH{1'b0}};
            else                    r_bcnt <= r_bcnt + BCNT_WIDTH'(1);
        end else begin
            r_bcnt <= r_bcnt;
        end
    end

    assign out_last_o = out_valid_o && (r_bcnt == BCNT_MAX);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{BURST_LEN, BCNT_WIDTH};
    assign out_last_o   = 1'b0;
`endif

endmodule
